fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and state encoding for the instruction fetch unit.
package fetch_unit_pkg;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          ILEN = 32;
    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FLUSH} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer holding {pc, instruction} pairs with synchronous flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_cnt;
    logic             w_full, w_push, w_pop;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    assign w_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    // The request throttle upstream must make a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        assert (!(rst_n && i_push && !i_flush && w_full && !w_pop));
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetcher with credit-limited requests, buffering and redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [31:0]     imem_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] instruction,
    output logic [31:0]     inst_pc,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t          r_state;
    logic [31:0]     r_pc;
    logic [CW-1:0]   r_out, r_drop, w_cnt, w_drop_nx;
    logic [CW:0]     w_load;
    logic [63:0]     w_head;
    logic [31:0]     w_resp_pc;
    logic            w_hs, w_pop, w_take, w_resp, w_empty, w_unused_lsb;
    assign w_unused_lsb   = ^redirect_pc[1:0];
    assign w_pop          = inst_valid & inst_ready & ~redirect;
    // A pop this cycle frees a slot, which keeps one fetch per cycle flowing at DEPTH 2.
    assign w_load         = {1'b0, r_out} + {1'b0, w_cnt} - (CW+1)'(w_pop);
    assign imem_req_valid = (r_state != ST_RESET) & ~redirect & (w_load < (CW+1)'(DEPTH));
    assign imem_addr      = r_pc;
    assign w_hs           = imem_req_valid & imem_req_ready;
    assign w_resp         = imem_resp_valid & ((r_drop != '0) | (r_out != '0));
    assign w_take         = imem_resp_valid & (r_drop == '0) & (r_out != '0) & ~redirect;
    // Responses are in order, so the oldest live request sits r_out words behind the fetch PC.
    assign w_resp_pc      = r_pc - (32'(r_out) << 2);
    assign w_drop_nx      = redirect ? r_drop + r_out - CW'(w_resp)
                                     : r_drop - CW'(imem_resp_valid && r_drop != '0);
    assign inst_valid     = ~w_empty;
    assign instruction    = w_head[31:0];
    assign inst_pc        = w_head[63:32];
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_take),
        .i_data  ({w_resp_pc, imem_resp_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
        end else if (r_state == ST_RESET) begin
            r_state <= ST_RUN;
        end else begin
            r_drop  <= w_drop_nx;
            r_state <= (w_drop_nx != '0) ? ST_FLUSH : ST_RUN;
            if (redirect) begin
                r_pc  <= {redirect_pc[31:2], 2'b00};
                r_out <= '0;
            end else begin
                r_pc  <= w_hs ? r_pc + 32'd4 : r_pc;
                r_out <= r_out + CW'(w_hs) - CW'(w_take);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for redirect, wrap and mid-stream reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        imem_req_valid, imem_req_ready = 1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 0;
    logic [31:0] imem_resp_data = 0;
    logic        inst_valid, inst_ready = 1;
    logic [31:0] instruction, inst_pc;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    int          checks = 0, failures = 0;
    logic [31:0] mem_q[$];
    logic        mem_hold = 0, s_hs = 0;
    logic [31:0] s_a = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory: answers each accepted request one cycle later with ~addr, in order; mem_hold stalls it.
    always @(negedge clk) begin
        s_hs = imem_req_valid & imem_req_ready;
        s_a  = imem_addr;
    end
    always @(posedge clk) begin
        if (s_hs) mem_q.push_back(s_a);
        #1;
        if (mem_q.size() != 0 && !mem_hold) begin
            imem_resp_valid = 1;
            imem_resp_data  = ~mem_q.pop_front();
        end else begin
            imem_resp_valid = 0;
        end
    end

    typedef struct packed {
        logic        rr, ir, rv;
        logic [31:0] a;
        logic        iv;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [20];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 0;
        mem_q.delete();
        cyc();
        rst_n = 1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
        vt[10] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        vt[12] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
        vt[13] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
        vt[14] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h20};
        vt[16] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00};
        vt[17] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00};
        vt[18] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b0, 32'h00};
        vt[19] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h24};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_RESET));
        cyc();
        rst_n = 1;

        // Streaming, decoder back-pressure, memory back-pressure
        for (int i = 0; i < 20; i++) begin
            cyc();
            imem_req_ready = vt[i].rr;
            inst_ready     = vt[i].ir;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].rv));
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].a);
            chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].iv));
            if (vt[i].iv) begin
                chk($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].pc);
                chk($sformatf("vec%0d_instruction", i), instruction, ~vt[i].pc);
            end
        end

        // Redirect with two requests outstanding: both late responses dropped
        imem_req_ready = 1;
        inst_ready = 1;
        mem_hold = 1;
        do_reset();
        cyc(); @(negedge clk); chk("rdA_c1_addr", imem_addr, 32'h0);
        cyc(); @(negedge clk); chk("rdA_c2_addr", imem_addr, 32'h4);
        cyc(); redirect = 1; redirect_pc = 32'h0000_0100; mem_hold = 0;
        @(negedge clk); chk("rdA_c3_req_valid", 32'(imem_req_valid), 0);
        cyc(); redirect = 0;
        @(negedge clk);
        chk("rdA_c4_state", 32'(dut.r_state), 32'(ST_FLUSH));
        chk("rdA_c4_addr", imem_addr, 32'h100);
        chk("rdA_c4_req_valid", 32'(imem_req_valid), 1);
        chk("rdA_c4_inst_valid", 32'(inst_valid), 0);
        cyc(); @(negedge clk);
        chk("rdA_c5_state", 32'(dut.r_state), 32'(ST_FLUSH));
        chk("rdA_c5_addr", imem_addr, 32'h104);
        chk("rdA_c5_inst_valid", 32'(inst_valid), 0);
        cyc(); @(negedge clk);
        chk("rdA_c6_state", 32'(dut.r_state), 32'(ST_RUN));
        chk("rdA_c6_inst_valid", 32'(inst_valid), 0);
        cyc(); @(negedge clk);
        chk("rdA_c7_inst_valid", 32'(inst_valid), 1);
        chk("rdA_c7_inst_pc", inst_pc, 32'h100);
        chk("rdA_c7_instruction", instruction, ~32'h100);

        // Redirect coinciding with response and pop; alignment and PC wrap
        do_reset();
        cyc(); cyc();
        cyc(); redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rdB_c3_req_valid", 32'(imem_req_valid), 0);
        chk("rdB_c3_inst_pc", inst_pc, 32'h0);
        cyc(); redirect = 0;
        @(negedge clk);
        chk("rdB_c4_inst_valid", 32'(inst_valid), 0);
        chk("rdB_c4_addr", imem_addr, 32'hFFFF_FFFC);
        chk("rdB_c4_state", 32'(dut.r_state), 32'(ST_RUN));
        cyc(); @(negedge clk);
        chk("rdB_c5_wrap_addr", imem_addr, 32'h0);
        cyc(); redirect = 1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("rdB_c6_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("rdB_c6_instruction", instruction, 32'h0000_0003);
        chk("rdB_c6_req_valid", 32'(imem_req_valid), 0);
        cyc(); redirect = 0;
        @(negedge clk);
        chk("rdB_c7_inst_valid", 32'(inst_valid), 0);
        chk("rdB_c7_addr", imem_addr, 32'h100);
        chk("rdB_c7_req_valid", 32'(imem_req_valid), 1);
        cyc(); @(negedge clk); chk("rdB_c8_addr", imem_addr, 32'h104);
        cyc(); @(negedge clk); chk("rdB_c9_inst_pc", inst_pc, 32'h100);

        // Mid-stream reset with two outstanding; stale responses after release ignored
        mem_hold = 1;
        do_reset();
        cyc(); cyc();
        cyc(); rst_n = 0; mem_hold = 0;
        @(negedge clk);
        chk("rsC_req_valid", 32'(imem_req_valid), 0);
        chk("rsC_inst_valid", 32'(inst_valid), 0);
        chk("rsC_instruction", instruction, 0);
        chk("rsC_inst_pc", inst_pc, 0);
        chk("rsC_addr", imem_addr, 32'h0);
        cyc(); rst_n = 1;
        @(negedge clk); chk("rsC_c4_req_valid", 32'(imem_req_valid), 0);
        cyc(); @(negedge clk);
        chk("rsC_c5_req_valid", 32'(imem_req_valid), 1);
        chk("rsC_c5_addr", imem_addr, 32'h0);
        chk("rsC_c5_inst_valid", 32'(inst_valid), 0);
        cyc(); @(negedge clk);
        chk("rsC_c6_inst_valid", 32'(inst_valid), 0);
        chk("rsC_c6_addr", imem_addr, 32'h4);
        cyc(); @(negedge clk);
        chk("rsC_c7_inst_valid", 32'(inst_valid), 1);
        chk("rsC_c7_inst_pc", inst_pc, 32'h0);
        chk("rsC_c7_instruction", instruction, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
